// File: rtl/usblogic_pkg.sv
// Shared definitions for the logic-analyser capture path: sequencer states,
// command register map and ctrl-word bit positions.
package usblogic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [2:0] ADDR_CTRL       = 3'd0;
    localparam logic [2:0] ADDR_TRIG_MASK  = 3'd1;
    localparam logic [2:0] ADDR_TRIG_VALUE = 3'd2;
    localparam logic [2:0] ADDR_EDGE_MASK  = 3'd3;
    localparam logic [2:0] ADDR_DIV        = 3'd4;
    localparam logic [2:0] ADDR_COUNT_LO   = 3'd5;
    localparam logic [2:0] ADDR_COUNT_HI   = 3'd6;

    localparam int ARM_BIT   = 0;
    localparam int ABORT_BIT = 1;

endpackage

// File: rtl/capture_trigger.sv
// Trigger matcher: combines a level pattern with edge-qualified bits.
// prev holds the probe word seen at the previous armed tick; on the first
// tick after arming there is no valid history, so edge bits cannot match.
module capture_trigger #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [DW-1:0] din_q,
    input  logic [DW-1:0] mask,
    input  logic [DW-1:0] value,
    input  logic [DW-1:0] edge_mask,
    input  logic          first_tick,
    output logic          hit
);

    logic [DW-1:0] prev;
    logic [DW-1:0] level_diff;
    logic [DW-1:0] edge_sel;
    logic [DW-1:0] edge_ok_bits;
    logic          level_ok;
    logic          edge_ok;

    // Level bits must equal the target value; edge bits are excluded here.
    assign level_diff   = (din_q ^ value) & mask & ~edge_mask;
    assign level_ok     = (level_diff == '0);

    // An edge bit matches when it changed since the last tick and landed on the target.
    assign edge_sel     = edge_mask & mask;
    assign edge_ok_bits = (prev ^ din_q) & ~(din_q ^ value);
    assign edge_ok      = first_tick ? (edge_sel == '0)
                                     : ((edge_ok_bits & edge_sel) == edge_sel);

    assign hit = tick && level_ok && edge_ok;

    // Remember the probe word at every armed tick for the next edge comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (tick) begin
            prev <= din_q;
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// Logic-analyser acquisition sequencer: host-programmed trigger, sample-rate
// divider and sample count; streams N samples to the USB writer over a
// valid/ready handshake, flagging samples lost to back-pressure.
module capture_sequencer #(
    parameter int DW   = 16,
    parameter int CW   = 32,
    parameter int DIVW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_addr,
    input  logic [15:0]   cmd_data,
    output logic          smp_valid,
    output logic [DW-1:0] smp_data,
    input  logic          smp_ready,
    output logic [1:0]    state,
    output logic          done,
    output logic          overflow
);

    import usblogic_pkg::*;

    cap_state_t    state_q;
    cap_state_t    state_d;

    logic [DW-1:0]   din_q;
    logic [DW-1:0]   trig_mask;
    logic [DW-1:0]   trig_value;
    logic [DW-1:0]   edge_mask;
    logic [DIVW-1:0] div_reg;
    logic [DIVW-1:0] div_cnt;
    logic [15:0]     count_lo;
    logic [15:0]     count_hi;
    logic [CW-1:0]   remaining;
    logic            first_tick;

    logic arm_wr;
    logic abort_wr;
    logic cfg_open;
    logic active;
    logic tick;
    logic arm_tick;
    logic hit;
    logic sample_tick;
    logic load;
    logic issue;
    logic dec;

    assign arm_wr   = cmd_valid && (cmd_addr == ADDR_CTRL) && cmd_data[ARM_BIT];
    assign abort_wr = cmd_valid && (cmd_addr == ADDR_CTRL) && cmd_data[ABORT_BIT];
    assign cfg_open = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign active   = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign tick     = active && (div_cnt == div_reg);
    assign arm_tick = tick && (state_q == ST_ARMED);

    // In ARMED a sample is taken only on the triggering tick; in CAPTURE on every tick.
    assign sample_tick = (state_q == ST_ARMED) ? hit : ((state_q == ST_CAPTURE) && tick);

    assign state = state_q;
    assign done  = (state_q == ST_DONE);

    capture_trigger #(
        .DW(DW)
    ) u_trigger (
        .clk       (clk),
        .rst       (rst),
        .tick      (arm_tick),
        .din_q     (din_q),
        .mask      (trig_mask),
        .value     (trig_value),
        .edge_mask (edge_mask),
        .first_tick(first_tick),
        .hit       (hit)
    );

    // Register the probe once; all trigger and sample decisions use din_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    // Configuration writes are frozen while an acquisition is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_mask  <= '0;
            trig_value <= '0;
            edge_mask  <= '0;
            div_reg    <= '0;
            count_lo   <= '0;
            count_hi   <= '0;
        end else if (cmd_valid && cfg_open) begin
            case (cmd_addr)
                ADDR_TRIG_MASK:  trig_mask  <= DW'(cmd_data);
                ADDR_TRIG_VALUE: trig_value <= DW'(cmd_data);
                ADDR_EDGE_MASK:  edge_mask  <= DW'(cmd_data);
                ADDR_DIV:        div_reg    <= DIVW'(cmd_data);
                ADDR_COUNT_LO:   count_lo   <= cmd_data;
                ADDR_COUNT_HI:   count_hi   <= cmd_data;
                default:         ;
            endcase
        end
    end

    // Divider counts div+1 clocks per tick, restarting from zero on every arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (load || !active || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIVW'(1);
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle sample decisions; abort overrides everything.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        issue   = 1'b0;
        dec     = 1'b0;
        if (abort_wr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_wr) begin
                        state_d = ST_ARMED;
                        load    = 1'b1;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (sample_tick) begin
                        issue   = 1'b1;
                        state_d = ST_CAPTURE;
                        // A zero count means free-running capture with no countdown.
                        if (remaining != '0) begin
                            dec = 1'b1;
                            if (remaining == CW'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sample budget and first-tick marker, both reloaded on arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining  <= '0;
            first_tick <= 1'b0;
        end else begin
            if (load) begin
                remaining <= CW'({count_hi, count_lo});
            end else if (dec) begin
                remaining <= remaining - CW'(1);
            end
            if (load) begin
                first_tick <= 1'b1;
            end else if (arm_tick) begin
                first_tick <= 1'b0;
            end
        end
    end

    // Output handshake: a tick that finds the previous sample unaccepted drops the new one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp_valid <= 1'b0;
            smp_data  <= '0;
            overflow  <= 1'b0;
        end else if (abort_wr) begin
            smp_valid <= 1'b0;
        end else begin
            if (load) begin
                overflow <= 1'b0;
            end
            if (issue) begin
                if (smp_valid && !smp_ready) begin
                    overflow <= 1'b1;
                end else begin
                    smp_valid <= 1'b1;
                    smp_data  <= din_q;
                end
            end else if (smp_ready) begin
                smp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: a directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        smp_ready = 1'b0;
    logic [1:0]  state;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    capture_sequencer #(.DW(16), .CW(32), .DIVW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .cmd_valid(cmd_valid),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .smp_valid(smp_valid),
        .smp_data (smp_data),
        .smp_ready(smp_ready),
        .state    (state),
        .done     (done),
        .overflow (overflow)
    );

    typedef struct {
        logic        cv;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] din;
        logic        rdy;
        logic [1:0]  st;
        logic        v;
        logic [15:0] sd;
        logic        dn;
        logic        ov;
    } vec_t;

    vec_t tbl [19];

    // ---------------- behavioural reference model ----------------
    int          m_phase;
    logic [15:0] m_mask, m_val, m_edge, m_div, m_clo, m_chi;
    logic [15:0] m_dq, m_prev, m_data;
    longint unsigned m_since;
    longint      m_left;
    bit          m_seen, m_cont, m_valid, m_ovf;
    bit          model_on = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_mask = '0; m_val = '0; m_edge = '0; m_div = '0;
        m_clo = '0; m_chi = '0; m_dq = '0; m_prev = '0; m_data = '0;
        m_since = 0; m_left = 0; m_seen = 0; m_cont = 0; m_valid = 0; m_ovf = 0;
    endtask

    function automatic bit trig_ok(input logic [15:0] dq, input logic [15:0] pv, input bit first);
        for (int i = 0; i < 16; i++) begin
            if (m_mask[i]) begin
                if (dq[i] !== m_val[i]) return 1'b0;
                if (m_edge[i] && (first || pv[i] === dq[i])) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit arm_w, abort_w, active, tick, issue;
        int nxt;
        int unsigned period;
        arm_w   = cmd_valid && (cmd_addr == 3'd0) && cmd_data[0];
        abort_w = cmd_valid && (cmd_addr == 3'd0) && cmd_data[1];
        active  = (m_phase == 1) || (m_phase == 2);
        period  = 32'(m_div) + 1;
        tick    = active && ((m_since % period) == period - 1);
        issue   = 1'b0;
        nxt     = m_phase;
        if (active) m_since++;
        if (m_phase == 1 && tick) begin
            issue  = trig_ok(m_dq, m_prev, !m_seen);
            m_prev = m_dq;
            m_seen = 1'b1;
        end
        if (m_phase == 2 && tick) issue = 1'b1;
        if (abort_w) begin
            nxt     = 0;
            m_valid = 1'b0;
        end else begin
            if (issue) begin
                if (m_valid && !smp_ready) m_ovf = 1'b1;
                else begin m_valid = 1'b1; m_data = m_dq; end
                nxt = 2;
                if (!m_cont) begin
                    m_left--;
                    if (m_left == 0) nxt = 3;
                end
            end else if (smp_ready) begin
                m_valid = 1'b0;
            end
            if ((m_phase == 0 || m_phase == 3) && arm_w) begin
                nxt     = 1;
                m_left  = longint'({m_chi, m_clo});
                m_cont  = (m_left == 0);
                m_ovf   = 1'b0;
                m_since = 0;
                m_seen  = 1'b0;
            end
        end
        if (cmd_valid && (m_phase == 0 || m_phase == 3)) begin
            case (cmd_addr)
                3'd1: m_mask = cmd_data;
                3'd2: m_val  = cmd_data;
                3'd3: m_edge = cmd_data;
                3'd4: m_div  = cmd_data;
                3'd5: m_clo  = cmd_data;
                3'd6: m_chi  = cmd_data;
                default: ;
            endcase
        end
        m_dq    = din;
        m_phase = nxt;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [20:0] obs();
        return {state, smp_valid, smp_data, done, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        logic [20:0] e;
        e = {2'(m_phase), m_valid, m_data, (m_phase == 3), m_ovf};
        check("model", 32'(obs()), 32'(e));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (model_on) model_step();
        @(negedge clk);
        if (model_on) model_check();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        cycle();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    endtask

    function automatic vec_t mk(input logic cv, input logic [2:0] a, input logic [15:0] d,
                                input logic [15:0] di, input logic r, input logic [1:0] st,
                                input logic v, input logic [15:0] sd, input logic dn, input logic ov);
        vec_t x;
        x.cv = cv; x.addr = a; x.data = d; x.din = di; x.rdy = r;
        x.st = st; x.v = v; x.sd = sd; x.dn = dn; x.ov = ov;
        return x;
    endfunction

    task automatic rand_inputs();
        int r;
        din = 16'($urandom);
        smp_ready = ($urandom_range(0, 9) < 7);
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        r = $urandom_range(0, 99);
        if (r < 5) begin
            cmd_valid = 1'b1;
            cmd_addr  = 3'($urandom_range(0, 7));
            case (cmd_addr)
                3'd0: begin
                    r = $urandom_range(0, 9);
                    cmd_data = (r < 5) ? 16'h1 : (r < 8) ? 16'h2 : (r < 9) ? 16'h3 : 16'h0;
                end
                3'd1, 3'd2, 3'd3: cmd_data = 16'($urandom_range(0, 15));
                3'd4: cmd_data = 16'($urandom_range(0, 3));
                3'd5: cmd_data = 16'($urandom_range(0, 6));
                3'd6: cmd_data = 16'h0;
                default: cmd_data = 16'($urandom);
            endcase
        end else if (r < 15 && (m_phase == 0 || m_phase == 3)) begin
            cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_data = 16'h1;
        end
    endtask

    initial begin
        int t, n, first_t, last_t;
        int times[$];
        logic [15:0] first_d;

        // Reset state
        #12;
        check("reset_outputs", 32'(obs()), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table: count=4 ramp capture, overflow run with count=5, abort/arm corners
        tbl[0]  = mk(1, 3'd5, 16'd4, 16'h000F, 1, 2'd0, 0, 16'h0000, 0, 0);
        tbl[1]  = mk(1, 3'd0, 16'd1, 16'h0010, 1, 2'd1, 0, 16'h0000, 0, 0);
        tbl[2]  = mk(0, 3'd0, 16'd0, 16'h0011, 1, 2'd2, 1, 16'h0010, 0, 0);
        tbl[3]  = mk(0, 3'd0, 16'd0, 16'h0012, 1, 2'd2, 1, 16'h0011, 0, 0);
        tbl[4]  = mk(0, 3'd0, 16'd0, 16'h0013, 1, 2'd2, 1, 16'h0012, 0, 0);
        tbl[5]  = mk(0, 3'd0, 16'd0, 16'h0014, 1, 2'd3, 1, 16'h0013, 1, 0);
        tbl[6]  = mk(0, 3'd0, 16'd0, 16'h0015, 1, 2'd3, 0, 16'h0013, 1, 0);
        tbl[7]  = mk(1, 3'd5, 16'd5, 16'h0016, 1, 2'd3, 0, 16'h0013, 1, 0);
        tbl[8]  = mk(1, 3'd0, 16'd1, 16'h0018, 1, 2'd1, 0, 16'h0013, 0, 0);
        tbl[9]  = mk(0, 3'd0, 16'd0, 16'h0019, 1, 2'd2, 1, 16'h0018, 0, 0);
        tbl[10] = mk(0, 3'd0, 16'd0, 16'h001A, 0, 2'd2, 1, 16'h0018, 0, 1);
        tbl[11] = mk(0, 3'd0, 16'd0, 16'h001B, 0, 2'd2, 1, 16'h0018, 0, 1);
        tbl[12] = mk(0, 3'd0, 16'd0, 16'h001C, 0, 2'd2, 1, 16'h0018, 0, 1);
        tbl[13] = mk(0, 3'd0, 16'd0, 16'h001D, 1, 2'd3, 1, 16'h001C, 1, 1);
        tbl[14] = mk(0, 3'd0, 16'd0, 16'h001E, 1, 2'd3, 0, 16'h001C, 1, 1);
        tbl[15] = mk(1, 3'd0, 16'd3, 16'h001F, 1, 2'd0, 0, 16'h001C, 0, 1);
        tbl[16] = mk(1, 3'd0, 16'd1, 16'h0020, 1, 2'd1, 0, 16'h001C, 0, 0);
        tbl[17] = mk(1, 3'd0, 16'd1, 16'h0021, 1, 2'd2, 1, 16'h0020, 0, 0);
        tbl[18] = mk(1, 3'd0, 16'd2, 16'h0022, 1, 2'd0, 0, 16'h0020, 0, 0);

        for (int i = 0; i < 19; i++) begin
            cmd_valid = tbl[i].cv; cmd_addr = tbl[i].addr; cmd_data = tbl[i].data;
            din = tbl[i].din; smp_ready = tbl[i].rdy;
            cycle();
            check($sformatf("table_row%0d", i), 32'(obs()),
                  32'({tbl[i].st, tbl[i].v, tbl[i].sd, tbl[i].dn, tbl[i].ov}));
        end
        cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;

        // Level pattern trigger on low byte
        din = 16'h0000; smp_ready = 1'b1;
        wr(3'd1, 16'h00FF); wr(3'd2, 16'h00A5); wr(3'd5, 16'd2);
        wr(3'd0, 16'h0001);
        for (int i = 0; i < 10; i++) cycle();
        check("pattern_wait_armed", 32'({state, smp_valid}), 32'({2'd1, 1'b0}));
        din = 16'h12A5; n = 0; first_t = 0; first_d = '0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (smp_valid) begin
                n++;
                if (n == 1) begin first_t = i; first_d = smp_data; end
            end
        end
        check("pattern_first_data", 32'(first_d), 32'h12A5);
        check("pattern_latency", 32'(first_t), 32'd2);
        check("pattern_samples", 32'(n), 32'd2);
        check("pattern_done", 32'({state, done}), 32'({2'd3, 1'b1}));

        // Rising-edge trigger on bit 0
        wr(3'd1, 16'h0001); wr(3'd2, 16'h0001); wr(3'd3, 16'h0001); wr(3'd5, 16'd1);
        din = 16'h0001; cycle(); cycle();
        wr(3'd0, 16'h0001);
        for (int i = 0; i < 6; i++) cycle();
        check("edge_held_high", 32'({state, smp_valid}), 32'({2'd1, 1'b0}));
        din = 16'h0000; cycle(); cycle();
        check("edge_falling", 32'({state, smp_valid}), 32'({2'd1, 1'b0}));
        din = 16'h0001; t = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (smp_valid && t == 0) begin t = i; first_d = smp_data; end
        end
        check("edge_rise_latency", 32'(t), 32'd2);
        check("edge_rise_data", 32'(first_d), 32'h0001);

        // Divider spacing, div=3, count=3
        wr(3'd1, 16'h0000); wr(3'd3, 16'h0000); wr(3'd4, 16'd3); wr(3'd5, 16'd3);
        wr(3'd0, 16'h0001);
        times.delete();
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (smp_valid) times.push_back(i);
        end
        check("div3_pulses", 32'(times.size()), 32'd3);
        if (times.size() == 3) begin
            check("div3_first", 32'(times[0]), 32'd4);
            check("div3_gap1", 32'(times[1] - times[0]), 32'd4);
            check("div3_gap2", 32'(times[2] - times[1]), 32'd4);
        end
        check("div3_done", 32'(state), 32'd3);

        // Continuous capture, ignored div write, back-pressure, abort
        wr(3'd4, 16'd1); wr(3'd5, 16'd0);
        wr(3'd0, 16'h0001);
        for (int i = 0; i < 4; i++) cycle();
        wr(3'd4, 16'd0);
        times.delete();
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (smp_valid) times.push_back(i);
        end
        check("cont_pulses", 32'(times.size() >= 3), 32'd1);
        if (times.size() >= 3) begin
            check("cont_gap1", 32'(times[1] - times[0]), 32'd2);
            check("cont_gap2", 32'(times[2] - times[1]), 32'd2);
        end
        smp_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("cont_backpressure", 32'({state, smp_valid, overflow}), 32'({2'd2, 1'b1, 1'b1}));
        wr(3'd0, 16'h0002);
        check("abort_idle", 32'({state, smp_valid}), 32'({2'd0, 1'b0}));

        // Asynchronous reset in the middle of a capture
        wr(3'd0, 16'h0001);
        for (int i = 0; i < 4; i++) cycle();
        check("pre_reset_capture", 32'({state, smp_valid, overflow}), 32'({2'd2, 1'b1, 1'b1}));
        #2 rst = 1'b0;
        #1 check("async_reset", 32'(obs()), 32'h0);
        @(negedge clk);
        din = '0; smp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        model_on = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end
        model_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sequences logic-analyser acquisition between the 16-bit probe input and the USB slave-FIFO write interface. The host programs trigger pattern, sample-rate divider and sample count through a command-word port. The block then arms, waits for the trigger and streams exactly N samples over a valid/ready handshake. It sits between the probe sampling register and usb_sinterface, replacing free-running capture.

Parameters:
DW, 16, probe/sample data width
CW, 32, sample-count width (loaded as two 16-bit words)
DIVW, 16, sample-rate divider width

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  asynchronous, active-low reset
din  in  DW  probe input, already synchronous to clk
cmd_valid  in  1  one-cycle command write strobe
cmd_addr  in  3  register select: 0 ctrl, 1 trig_mask, 2 trig_value, 3 edge_mask, 4 div, 5 count_lo, 6 count_hi, 7 reserved (ignored)
cmd_data  in  16  command payload; ctrl bit0 = arm, bit1 = abort
smp_valid  out  1  sample available to USB writer
smp_data  out  DW  captured sample
smp_ready  in  1  USB writer accepts sample this cycle
state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
done  out  1  high while in DONE
overflow  out  1  sticky: at least one sample dropped since last arm

Behaviour:
- Reset (rst low, async): state IDLE; smp_valid 0; smp_data 0; done 0; overflow 0; all config registers 0; counters 0.
- din is registered into din_q every clk. All evaluation uses din_q.
- Config writes (addr 1-6) take effect only in IDLE or DONE; ignored in ARMED/CAPTURE. ctrl writes are accepted in any state.
- Tick generator: tick every div+1 clocks. div=0 gives a tick every cycle. The divider counter clears on arm, so the first tick occurs div+1 cycles after the arm write.
- Trigger, evaluated at each tick in ARMED:
  - level term: ((din_q ^ trig_value) & trig_mask & ~edge_mask) == 0
  - edge term: for every bit in (edge_mask & trig_mask), prev differs from din_q and din_q equals trig_value
  - prev is din_q latched at the previous tick. The first tick after arm only loads prev; edge bits cannot match on it.
  - trig_mask=0 gives an immediate trigger on the first tick.
- FSM:
  - IDLE: arm moves to ARMED; remaining <= {count_hi,count_lo}; overflow cleared.
  - ARMED: on a trigger tick, move to CAPTURE. The triggering sample is sample #1.
  - CAPTURE: every tick issues one sample and decrements remaining. When remaining reaches 0 after the issue, move to DONE.
  - count=0 means continuous capture until abort (no decrement, never DONE).
  - DONE: done=1. arm restarts as from IDLE.
  - abort from any state goes to IDLE next cycle and clears smp_valid. abort+arm in the same write: abort wins.
  - arm in ARMED/CAPTURE is ignored.
- Output handshake: at a capture tick, smp_valid=1 and smp_data=sample on the following cycle. Both hold until smp_ready=1.
  - Tick while smp_valid && !smp_ready: the new sample is dropped, overflow=1, and the sample still counts toward remaining (time-accurate).
  - Tick coinciding with smp_ready on a pending sample: the old sample is accepted and the new one is loaded; no overflow.
- Transition to DONE does not kill a pending sample. smp_valid stays until accepted.
- Latency: din edge to smp_valid = 2 clk at div=0, excluding trigger wait.

Decomposition:
- Shared package usblogic_pkg holds:
  - state enum (IDLE/ARMED/CAPTURE/DONE)
  - cmd address constants
  - ctrl bit positions ARM_BIT=0, ABORT_BIT=1
- One sub-module, capture_trigger:
  - owns prev register and match logic
  - inputs: tick, din_q, mask, value, edge_mask, first_tick
  - output: hit
- Tick divider and FSM stay in the top.

Test Plan:
- div=0, mask=0, count=4, smp_ready=1, arm, din ramps 0,1,2... -> exactly 4 samples, consecutive values starting at the first tick value; state=DONE; done=1; overflow=0.
- mask=0x00FF, value=0x00A5, edge=0, din=0x12A5 appears after 10 cycles, count=2 -> first smp_data=0x12A5, 2 samples total, then DONE.
- edge_mask=0x0001, mask=0x0001, value=0x0001, din bit0 held 1 at arm then 0->1 -> no trigger on first tick or while held high; trigger on the rising tick only.
- div=3, count=3, smp_ready=1 -> smp_valid pulses spaced exactly 4 clk apart; 3 pulses.
- div=0, count=5, smp_ready=0 for 3 cycles after first sample -> overflow=1, 5 ticks consumed, first sample still held and delivered on ready, DONE reached.
- count=0 continuous, abort mid-CAPTURE with smp_valid=1 -> next cycle state=IDLE and smp_valid=0. Writes to div during CAPTURE are ignored (read back by subsequent tick spacing). Async rst low mid-capture -> all outputs 0 immediately.
